// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: state encoding, tap clamp and default MAC latency for the FIR sequencer
package fir_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_MAC, S_DRAIN, S_OUT, S_DONE} state_t;
  localparam int MAC_LAT_DEF = 2;
  function automatic int clamp_taps(input int tap_num, input int num_tap);
    return (tap_num >= 1 && tap_num <= num_tap) ? tap_num : num_tap;
  endfunction
endpackage

// File: rtl/fir_addr_gen.sv
// fir_addr_gen: circular history head, tap index k and modulo-T history address
module fir_addr_gen
  import fir_ctrl_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          step,
  input  logic          adv,
  input  logic [AW-1:0] t,
  output logic [AW-1:0] head,
  output logic [AW-1:0] k,
  output logic [AW-1:0] hist_addr,
  output logic          k_last
);
  logic [AW-1:0] head_q, head_d, k_q, k_d;
  always_comb begin
    k_last = k_q == t - 1'b1;
    hist_addr = head_q >= k_q ? head_q - k_q : head_q + (t - k_q);
    k_d = init ? '0 : step ? (k_last ? '0 : k_q + 1'b1) : k_q;
    head_d = init ? '0 : adv ? (head_q == t - 1'b1 ? '0 : head_q + 1'b1) : head_q;
  end
  always_ff @(posedge clk) begin
    head_q <= rst ? '0 : head_d;
    k_q <= rst ? '0 : k_d;
  end
  assign head = head_q;
  assign k = k_q;
endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: FIR engine sequencer (ap protocol, history clear, tap stepping, MAC gating); FIR_CYCLE_CNT_EN enables cycle_cnt
module fir_seq_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_TAP = 11,
  parameter int AW      = 4,
  parameter int LEN_W   = 32,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             ap_start,
  input  logic             ap_done_clr,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [AW-1:0]    cfg_tap_num,
  output logic             ap_idle,
  output logic             ap_done,
  output logic             tlast_err,
  input  logic             ss_tvalid,
  input  logic             ss_tlast,
  output logic             ss_tready,
  output logic             data_we,
  output logic [AW-1:0]    data_addr,
  output logic [AW-1:0]    tap_addr,
  output logic             mac_clr,
  output logic             mac_en,
  output logic             sm_tvalid,
  input  logic             sm_tready,
  output logic             sm_tlast,
  output logic [31:0]      cycle_cnt
);
  state_t state_q, state_d;
  logic [AW-1:0] t_q, t_d, head, k, hist_addr;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [7:0] drn_q, drn_d;
  logic done_q, done_d, err_q, err_d;
  logic start, accept, out_hs, last_smp, k_last, step;
  fir_addr_gen #(.AW(AW)) u_addr (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .init(start),
    .step(step),
    .adv(out_hs),
    .t(t_q),
    .head(head),
    .k(k),
    .hist_addr(hist_addr),
    .k_last(k_last)
  );
  always_comb begin
    start = ap_start && state_q == S_IDLE;
    accept = state_q == S_LOAD && ss_tvalid;
    out_hs = state_q == S_OUT && sm_tready;
    step = state_q == S_CLR || state_q == S_MAC;
    last_smp = cnt_q + 1'b1 == len_q;
    ap_idle = state_q == S_IDLE || state_q == S_DONE;
    ap_done = done_q || state_q == S_DONE;
    tlast_err = err_q;
    ss_tready = state_q == S_LOAD;
    data_we = state_q == S_CLR || accept;
    data_addr = state_q == S_CLR ? k : state_q == S_LOAD ? head : state_q == S_MAC ? hist_addr : '0;
    tap_addr = state_q == S_MAC ? k : '0;
    mac_clr = accept;
    mac_en = state_q == S_MAC;
    sm_tvalid = state_q == S_OUT;
    sm_tlast = sm_tvalid && last_smp;
    t_d = start ? AW'(clamp_taps(int'(cfg_tap_num), NUM_TAP)) : t_q;
    len_d = start ? cfg_len : len_q;
    cnt_d = start ? '0 : out_hs ? cnt_q + 1'b1 : cnt_q;
    drn_d = state_q == S_DRAIN ? drn_q + 1'b1 : '0;
    done_d = start ? 1'b0 : state_q == S_DONE ? 1'b1 : ap_done_clr ? 1'b0 : done_q;
    err_d = start ? 1'b0 : (accept && ss_tlast != last_smp) ? 1'b1 : err_q;
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ap_start) state_d = cfg_len == '0 ? S_DONE : S_CLR;
      S_CLR:   if (k_last) state_d = S_LOAD;
      S_LOAD:  if (ss_tvalid) state_d = S_MAC;
      S_MAC:   if (k_last) state_d = MAC_LAT == 0 ? S_OUT : S_DRAIN;
      S_DRAIN: if (drn_q == 8'(MAC_LAT - 1)) state_d = S_OUT;
      S_OUT:   if (sm_tready) state_d = last_smp ? S_DONE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    state_q <= wb_rst_i ? S_IDLE : state_d;
    t_q <= wb_rst_i ? '0 : t_d;
    len_q <= wb_rst_i ? '0 : len_d;
    cnt_q <= wb_rst_i ? '0 : cnt_d;
    drn_q <= wb_rst_i ? '0 : drn_d;
    done_q <= wb_rst_i ? 1'b0 : done_d;
    err_q <= wb_rst_i ? 1'b0 : err_d;
  end
`ifdef FIR_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;
  always_comb cyc_d = start ? '0 : (state_q != S_IDLE && cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;
  always_ff @(posedge wb_clk_i) cyc_q <= wb_rst_i ? '0 : cyc_d;
  assign cycle_cnt = cyc_q;
`else
  assign cycle_cnt = '0;
`endif
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: randomized self-checking bench for fir_seq_ctrl against a frame-level reference model
module tb_fir_seq_ctrl;
  localparam int NT = 11, LAT = 2;
  logic clk = 0, rst = 1, ap_start = 0, ap_done_clr = 0, ss_tvalid = 0, ss_tlast = 0, sm_tready = 0;
  logic [31:0] cfg_len = 0;
  logic [3:0] cfg_tap_num = 0;
  logic ap_idle, ap_done, tlast_err, ss_tready, data_we, mac_clr, mac_en, sm_tvalid, sm_tlast;
  logic [3:0] data_addr, tap_addr;
  logic [31:0] cycle_cnt;
  int cmp = 0, bad = 0;
  int n_out, n_in, n_mac, n_clr, done_cyc, hold_bad, rdy_bad, timed_out;
  int first_idle, first_err, first_done, done_err, done_idle;
  int lat[64], macs[64], out_last[64], clr_a[16];
  int daddr[64][16], taddr[64][16];
  always #5 clk = ~clk;
  fir_seq_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .ap_start(ap_start), .ap_done_clr(ap_done_clr),
    .cfg_len(cfg_len), .cfg_tap_num(cfg_tap_num), .ap_idle(ap_idle), .ap_done(ap_done),
    .tlast_err(tlast_err), .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .data_we(data_we), .data_addr(data_addr), .tap_addr(tap_addr), .mac_clr(mac_clr),
    .mac_en(mac_en), .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast),
    .cycle_cnt(cycle_cnt)
  );
  function automatic logic [16:0] outv();
    return {ap_idle, ap_done, tlast_err, ss_tready, data_we, mac_clr, mac_en, sm_tvalid, sm_tlast, data_addr, tap_addr};
  endfunction
  task automatic run_frame(input int len, input int tapn, input int tlast_at, input int vpct, input int rpct, input bit poke);
    int cyc, acc, vld;
    bit prev_stall, poked, poke_now;
    n_out = 0; n_in = 0; n_mac = 0; n_clr = 0; done_cyc = -1; hold_bad = 0; rdy_bad = 0; timed_out = 0;
    acc = 0; vld = -1; prev_stall = 0; poked = 0; poke_now = 0;
    done_err = -1; done_idle = -1;
    for (int i = 0; i < 64; i++) begin lat[i] = -1; macs[i] = 0; out_last[i] = 0; end
    @(posedge clk); #1;
    ap_start = 1; cfg_len = len; cfg_tap_num = 4'(tapn);
    @(posedge clk); #1;
    ap_start = 0;
    cyc = 0;
    while (1) begin
      ss_tvalid = $urandom_range(99) < vpct;
      ss_tlast = n_in + 1 == tlast_at;
      sm_tready = rpct < 0 ? (vld >= 0 && cyc - vld >= 5) : ($urandom_range(99) < rpct);
      @(negedge clk);
      if (cyc == 0) begin first_idle = ap_idle; first_err = tlast_err; first_done = ap_done; end
      if (data_we && !ss_tready) begin if (n_clr < 16) clr_a[n_clr] = data_addr; n_clr++; end
      if (mac_en) begin
        if (n_in > 0 && n_in <= 64 && macs[n_in-1] < 16) begin
          daddr[n_in-1][macs[n_in-1]] = data_addr;
          taddr[n_in-1][macs[n_in-1]] = tap_addr;
        end
        if (n_in > 0 && n_in <= 64) macs[n_in-1]++;
        n_mac++;
        if (poke && !poked) begin poked = 1; poke_now = 1; end
      end
      if (ss_tvalid && ss_tready) begin acc = cyc; n_in++; end
      if (sm_tvalid && ss_tready) rdy_bad++;
      if (prev_stall && !sm_tvalid) hold_bad++;
      if (sm_tvalid && vld < 0) begin vld = cyc; if (n_out < 64) lat[n_out] = cyc - acc; end
      if (sm_tvalid && sm_tready) begin if (n_out < 64) out_last[n_out] = sm_tlast; n_out++; vld = -1; end
      prev_stall = sm_tvalid && !sm_tready;
      if (ap_done) begin done_cyc = cyc; done_err = tlast_err; done_idle = ap_idle; break; end
      if (cyc > 3000) begin timed_out = 1; break; end
      @(posedge clk); #1;
      ap_start = poke_now;
      if (poke_now) begin cfg_len = 5; cfg_tap_num = 4'd3; end
      poke_now = 0;
      cyc++;
    end
    ss_tvalid = 0; ss_tlast = 0; sm_tready = 0; ap_start = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp++; if (outv() !== 17'h10000) begin bad++; $display("FAIL reset_outputs: got %h want %h", outv(), 17'h10000); end
    cmp++; if (cycle_cnt !== 0) begin bad++; $display("FAIL reset_cycle_cnt: got %0d want 0", cycle_cnt); end
    @(posedge clk); #1 rst = 0;
  endtask
  task automatic test_full_frame();
    int nl = 0;
    run_frame(64, 11, 64, 100, 100, 0);
    for (int i = 0; i < 64; i++) nl += out_last[i];
    cmp++; if (timed_out !== 0) begin bad++; $display("FAIL full_timeout: got %0d want 0", timed_out); end
    cmp++; if (n_out !== 64) begin bad++; $display("FAIL full_beats: got %0d want 64", n_out); end
    cmp++; if (nl !== 1) begin bad++; $display("FAIL full_tlast_count: got %0d want 1", nl); end
    cmp++; if (out_last[63] !== 1) begin bad++; $display("FAIL full_tlast_last: got %0d want 1", out_last[63]); end
    cmp++; if (done_err !== 0) begin bad++; $display("FAIL full_tlast_err: got %0d want 0", done_err); end
    cmp++; if (done_idle !== 1) begin bad++; $display("FAIL full_idle: got %0d want 1", done_idle); end
    cmp++; if (n_mac !== 64 * NT) begin bad++; $display("FAIL full_mac_total: got %0d want %0d", n_mac, 64 * NT); end
    cmp++; if (n_clr !== NT) begin bad++; $display("FAIL full_clr_count: got %0d want %0d", n_clr, NT); end
    for (int i = 0; i < NT; i++) begin
      cmp++; if (clr_a[i] !== i) begin bad++; $display("FAIL full_clr_addr[%0d]: got %0d want %0d", i, clr_a[i], i); end
    end
  endtask
  task automatic test_timing(input int tapn);
    int t = (tapn >= 1 && tapn <= NT) ? tapn : NT;
    run_frame(20, tapn, 20, 60, 100, 0);
    cmp++; if (n_out !== 20) begin bad++; $display("FAIL timing_beats T=%0d: got %0d want 20", t, n_out); end
    for (int s = 0; s < 20; s++) begin
      cmp++; if (lat[s] !== t + LAT + 1) begin bad++; $display("FAIL timing_latency T=%0d s=%0d: got %0d want %0d", t, s, lat[s], t + LAT + 1); end
      cmp++; if (macs[s] !== t) begin bad++; $display("FAIL timing_mac_count T=%0d s=%0d: got %0d want %0d", t, s, macs[s], t); end
      for (int k = 0; k < t && k < 16; k++) begin
        cmp++; if (daddr[s][k] !== ((s % t) - k + t) % t) begin bad++; $display("FAIL timing_data_addr T=%0d s=%0d k=%0d: got %0d want %0d", t, s, k, daddr[s][k], ((s % t) - k + t) % t); end
        cmp++; if (taddr[s][k] !== k) begin bad++; $display("FAIL timing_tap_addr T=%0d s=%0d k=%0d: got %0d want %0d", t, s, k, taddr[s][k], k); end
      end
    end
  endtask
  task automatic test_backpressure();
    run_frame(8, 11, 8, 100, -1, 0);
    cmp++; if (n_out !== 8) begin bad++; $display("FAIL bp_beats: got %0d want 8", n_out); end
    cmp++; if (hold_bad !== 0) begin bad++; $display("FAIL bp_valid_dropped: got %0d want 0", hold_bad); end
    cmp++; if (rdy_bad !== 0) begin bad++; $display("FAIL bp_ss_ready_in_out: got %0d want 0", rdy_bad); end
    cmp++; if (n_mac !== 8 * NT) begin bad++; $display("FAIL bp_mac_total: got %0d want %0d", n_mac, 8 * NT); end
    cmp++; if (out_last[7] !== 1) begin bad++; $display("FAIL bp_tlast: got %0d want 1", out_last[7]); end
  endtask
  task automatic test_tlast_err();
    run_frame(20, 11, 10, 80, 100, 0);
    cmp++; if (done_err !== 1) begin bad++; $display("FAIL tlast_early_err: got %0d want 1", done_err); end
    cmp++; if (n_out !== 20) begin bad++; $display("FAIL tlast_early_beats: got %0d want 20", n_out); end
    run_frame(4, 11, 4, 100, 100, 0);
    cmp++; if (first_err !== 0) begin bad++; $display("FAIL tlast_cleared_on_start: got %0d want 0", first_err); end
    cmp++; if (first_done !== 0) begin bad++; $display("FAIL done_cleared_on_start: got %0d want 0", first_done); end
    cmp++; if (first_idle !== 0) begin bad++; $display("FAIL idle_falls_on_start: got %0d want 0", first_idle); end
    cmp++; if (done_err !== 0) begin bad++; $display("FAIL tlast_ok_err: got %0d want 0", done_err); end
    run_frame(3, 11, 0, 100, 100, 0);
    cmp++; if (done_err !== 1) begin bad++; $display("FAIL tlast_missing_err: got %0d want 1", done_err); end
  endtask
  task automatic test_len_zero();
    run_frame(0, 11, 0, 100, 100, 0);
    cmp++; if (done_cyc !== 0) begin bad++; $display("FAIL len0_done_cycle: got %0d want 0", done_cyc); end
    cmp++; if (n_clr !== 0) begin bad++; $display("FAIL len0_no_clear: got %0d want 0", n_clr); end
    cmp++; if (n_out !== 0) begin bad++; $display("FAIL len0_beats: got %0d want 0", n_out); end
  endtask
  task automatic test_clamp(input int tapn);
    run_frame(2, tapn, 2, 100, 100, 0);
    cmp++; if (n_clr !== NT) begin bad++; $display("FAIL clamp%0d_clr: got %0d want %0d", tapn, n_clr, NT); end
    cmp++; if (macs[0] !== NT) begin bad++; $display("FAIL clamp%0d_macs: got %0d want %0d", tapn, macs[0], NT); end
    cmp++; if (lat[1] !== NT + LAT + 1) begin bad++; $display("FAIL clamp%0d_latency: got %0d want %0d", tapn, lat[1], NT + LAT + 1); end
  endtask
  task automatic test_start_ignored();
    run_frame(6, 11, 6, 100, 100, 1);
    cmp++; if (n_out !== 6) begin bad++; $display("FAIL ign_start_beats: got %0d want 6", n_out); end
    cmp++; if (n_mac !== 6 * NT) begin bad++; $display("FAIL ign_start_macs: got %0d want %0d", n_mac, 6 * NT); end
    cmp++; if (done_err !== 0) begin bad++; $display("FAIL ign_start_err: got %0d want 0", done_err); end
  endtask
  task automatic test_done_clr();
    ap_done_clr = 1;
    run_frame(2, 11, 2, 100, 100, 0);
    @(posedge clk); #1 ap_done_clr = 0;
    @(negedge clk);
    cmp++; if (ap_done !== 1) begin bad++; $display("FAIL done_set_wins: got %0d want 1", ap_done); end
    @(posedge clk); #1 ap_done_clr = 1;
    @(posedge clk); #1 ap_done_clr = 0;
    @(negedge clk);
    cmp++; if (ap_done !== 0) begin bad++; $display("FAIL done_clr: got %0d want 0", ap_done); end
  endtask
  task automatic test_reset_in_out();
    int n = 0;
    @(posedge clk); #1;
    ap_start = 1; cfg_len = 3; cfg_tap_num = 4'd11; ss_tvalid = 1; sm_tready = 0;
    @(posedge clk); #1 ap_start = 0;
    @(negedge clk);
    while (!sm_tvalid && n < 200) begin @(negedge clk); n++; end
    cmp++; if (sm_tvalid !== 1) begin bad++; $display("FAIL rst_out_reach: got %0d want 1", sm_tvalid); end
    rst = 1;
    @(negedge clk);
    cmp++; if (outv() !== 17'h10000) begin bad++; $display("FAIL rst_in_out_outputs: got %h want %h", outv(), 17'h10000); end
    cmp++; if (cycle_cnt !== 0) begin bad++; $display("FAIL rst_in_out_cycle_cnt: got %0d want 0", cycle_cnt); end
    @(posedge clk); #1 rst = 0; ss_tvalid = 0;
    run_frame(3, 5, 3, 100, 100, 0);
    cmp++; if (n_out !== 3) begin bad++; $display("FAIL rst_recover_beats: got %0d want 3", n_out); end
    cmp++; if (lat[0] !== 5 + LAT + 1) begin bad++; $display("FAIL rst_recover_latency: got %0d want %0d", lat[0], 5 + LAT + 1); end
  endtask
  task automatic test_cycle_cnt();
    run_frame(1, 11, 1, 100, 100, 0);
    @(negedge clk);
`ifdef FIR_CYCLE_CNT_EN
    cmp++; if (cycle_cnt !== 27) begin bad++; $display("FAIL cycle_cnt_total: got %0d want 27", cycle_cnt); end
    repeat (4) @(negedge clk);
    cmp++; if (cycle_cnt !== 27) begin bad++; $display("FAIL cycle_cnt_hold: got %0d want 27", cycle_cnt); end
`else
    cmp++; if (cycle_cnt !== 0) begin bad++; $display("FAIL cycle_cnt_tied: got %0d want 0", cycle_cnt); end
`endif
  endtask
  initial begin
    test_reset();
    test_full_frame();
    test_timing(11);
    test_timing($urandom_range(1, 10));
    test_timing(1);
    test_timing(7);
    test_backpressure();
    test_tlast_err();
    test_len_zero();
    test_clamp(0);
    test_clamp(15);
    test_start_ignored();
    test_done_clr();
    test_reset_in_out();
    test_cycle_cnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
Sequencing controller for the user-project FIR engine behind the Caravel wrapper. It handles the ap_start/ap_done/ap_idle protocol and zero-fills the data history RAM. It accepts input samples over a stream handshake and steps the tap and data RAM addresses per sample, one tap per cycle, over a circular history buffer. It gates the external MAC and presents each result on the output stream; it holds no arithmetic datapath itself.

Parameters:
NUM_TAP, 11, maximum taps and history-RAM depth
AW, 4, tap/data RAM address width (2**AW >= NUM_TAP)
LEN_W, 32, data_length counter width
MAC_LAT, 2, cycles from last mac_en to valid accumulator output

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
ap_start  in  1  one-cycle start pulse from config register
ap_done_clr  in  1  clears sticky ap_done (config read side effect)
cfg_len  in  LEN_W  samples per frame
cfg_tap_num  in  AW  active taps
ap_idle  out  1  controller idle
ap_done  out  1  sticky frame-complete flag
tlast_err  out  1  sticky: ss_tlast mismatched sample count
ss_tvalid  in  1  input sample valid
ss_tlast  in  1  input last marker
ss_tready  out  1  input sample accepted when valid&ready
data_we  out  1  write current ss sample into data RAM
data_addr  out  AW  data RAM address
tap_addr  out  AW  tap RAM address
mac_clr  out  1  clear accumulator
mac_en  out  1  accumulate product this cycle
sm_tvalid  out  1  output sample valid
sm_tready  in  1  downstream ready
sm_tlast  out  1  last output of frame
cycle_cnt  out  32  frame latency (see Optional Feature)

Behaviour:
- Reset: state IDLE; ap_idle=1; ap_done, tlast_err, ss_tready, data_we, mac_clr, mac_en, sm_tvalid, sm_tlast=0; addresses 0; head=0; sample count=0. Reset mid-frame aborts immediately and returns to these values.
- Effective taps T = cfg_tap_num if 1..NUM_TAP, else NUM_TAP. T and cfg_len are latched on accepted ap_start. cfg_len=0 completes immediately: 1 cycle of INIT is skipped; ap_done set next cycle.
- IDLE: ap_start -> CLR; ap_idle falls next cycle; ap_done and tlast_err cleared. ap_start is ignored when not IDLE.
- CLR: data_we=1 with zero data, data_addr 0..T-1, T cycles -> LOAD.
- LOAD: ss_tready=1. On ss_tvalid: data_we=1, data_addr=head, mac_clr=1 -> MAC with k=0.
- MAC: T cycles. mac_en=1, tap_addr=k, data_addr=(head-k) mod T, k increments -> DRAIN.
- DRAIN: MAC_LAT cycles idle -> OUT.
- OUT: sm_tvalid=1 and held stable until sm_tready. sm_tlast=1 on the cfg_len-th sample. On handshake: head=(head+1) mod T; count++. Then LOAD, or DONE if count==cfg_len.
- DONE: ap_done=1, ap_idle=1 -> IDLE, same cycle transition.
- ap_done_clr clears ap_done. If ap_done_clr and the set arrive in the same cycle, set wins.
- tlast_err is set if ss_tlast=1 on a sample other than the cfg_len-th, or 0 on the cfg_len-th. The frame still runs to cfg_len.
- Per-sample latency, ss accept to sm_tvalid: T+MAC_LAT+1 cycles.
- Head wraps at T-1 -> 0. Data address subtraction is modulo T, never modulo 2**AW.

Optional Feature:
FIR_CYCLE_CNT_EN
- Defined: a 32-bit counter clears on accepted ap_start and increments every non-IDLE cycle. It freezes on DONE; cycle_cnt holds the value until the next start. It saturates at 0xFFFFFFFF.
- Undefined: cycle_cnt tied 0; no counter logic.

Decomposition:
- Package fir_ctrl_pkg: state encoding (IDLE, CLR, LOAD, MAC, DRAIN, OUT, DONE), the tap clamp function, and the default MAC_LAT.
- One sub-module, fir_addr_gen: head pointer, tap index k, and modulo-T data address.
- The FSM and the handshakes stay in fir_seq_ctrl.

Test Plan:
- T=11, cfg_len=64, sm_tready=1, ss always valid, tlast on the 64th: 64 sm beats, sm_tlast only on the 64th, ap_done=1, tlast_err=0, ap_idle=1.
- Per-sample timing, MAC_LAT=2, T=11: sm_tvalid exactly 14 cycles after the ss handshake; exactly 11 mac_en pulses per sample; data_addr sequence for head=3 is 3,2,1,0,10,9,...,4.
- Backpressure with sm_tready low for 5 cycles: sm_tvalid held and ss_tready=0 throughout; no extra mac_en; correct count resumes.
- ss_tlast on sample 10 of cfg_len=20: tlast_err=1, frame completes at 20 outputs; the next ap_start clears tlast_err.
- cfg_tap_num=0 or 15: T=11 behaviour. ap_start during MAC: ignored. wb_rst_i asserted in OUT: all outputs return to reset values next cycle.
- FIR_CYCLE_CNT_EN, cfg_len=1, T=11, tready=1, ss valid immediately: cycle_cnt equals CLR+LOAD+MAC+DRAIN+OUT+DONE cycle total (11+1+11+2+1+1=27).
